// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first through one 1-bit
// full adder, one bit per clock, and holds the result until the next one completes.

module full_adder2 (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_si,
  output logic o_pi
);
  assign o_si = i_a ^ i_b ^ i_c;
  assign o_pi = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sr, w_a_nxt;
  logic [WIDTH-1:0] r_b_sr, w_b_nxt;
  logic [WIDTH-1:0] r_res_sr, w_res_nxt, w_res_shift;
  logic             r_carry_ff, w_carry_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_sum, w_sum_nxt;
  logic             r_cout, w_cout_nxt;
  logic             w_si, w_pi;

  full_adder2 u_fa (
    .i_a  (r_a_sr[0]),
    .i_b  (r_b_sr[0]),
    .i_c  (r_carry_ff),
    .o_si (w_si),
    .o_pi (w_pi)
  );

  // The new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_shift = w_si;
    end else begin : g_wn
      assign w_res_shift = {w_si, r_res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt = r_state;
    w_a_nxt     = r_a_sr;
    w_b_nxt     = r_b_sr;
    w_res_nxt   = r_res_sr;
    w_carry_nxt = r_carry_ff;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_sum_nxt   = r_sum;
    w_cout_nxt  = r_cout;

    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_a_nxt     = i_a;
          w_b_nxt     = i_b;
          w_carry_nxt = i_c;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_a_nxt     = r_a_sr >> 1;
        w_b_nxt     = r_b_sr >> 1;
        w_res_nxt   = w_res_shift;
        w_carry_nxt = w_pi;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_sum_nxt   = w_res_shift;
          w_cout_nxt  = w_pi;
          w_done_nxt  = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // NOTE: datapath shift registers are cleared too, so a reset mid-RUN leaves no stale bits.
      r_state    <= IDLE;
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_carry_ff <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a_sr     <= w_a_nxt;
      r_b_sr     <= w_b_nxt;
      r_res_sr   <= w_res_nxt;
      r_carry_ff <= w_carry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sum      <= w_sum_nxt;
      r_cout     <= w_cout_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_carry = r_cout;
endmodule
